// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- single-issue instruction fetch unit
//
// The unit walks one instruction at a time through five states:
//   REQ  : offer a fetch of the current PC to instruction memory
//   WAIT : wait for memory to return the word (or a bus error)
//   HOLD : offer the fetched word and its PC to decode
//   EXEC : wait for execute to resolve it (fall-through or redirect)
//   ERR  : halted on a bus error or a misaligned redirect, until rst
// With zero-wait memory and consumers, one instruction takes 4 cycles from
// REQ entry to the next REQ entry.
//
// Parameters
//   RESET_PC        PC loaded by reset
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready fetch request handshake, req_addr = current PC
//   resp_valid      fetch response strobe with resp_data / resp_err
//   inst_valid/ready decode handshake carrying inst / inst_pc
//   exe_done        execute resolved the accepted instruction
//   redirect_valid  taken branch/jump (qualified by exe_done), to redirect_target
//   fault, fault_pc sticky halt flag and the address that caused it
// ---------------------------------------------------------------------------
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory request
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  // instruction memory response
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        resp_err,
  // decode side
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  // execute feedback
  input  logic        exe_done,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  // fault reporting
  output logic        fault,
  output logic [31:0] fault_pc
);

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_EXEC = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] pc;

  // The fetch address is always the architectural PC; req_valid gates it.
  assign req_addr = pc;

  // req_valid, inst_valid and fault are registered alongside the state so
  // that each is high exactly while the FSM sits in REQ, HOLD or ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      fault      <= 1'b0;
      fault_pc   <= '0;
      req_valid  <= 1'b1;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (req_ready) begin
            state     <= S_WAIT;
            req_valid <= 1'b0;
          end
        end

        S_WAIT: begin
          if (resp_valid) begin
            if (resp_err) begin
              state    <= S_ERR;
              fault    <= 1'b1;
              fault_pc <= pc;
            end else begin
              state      <= S_HOLD;
              inst       <= resp_data;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (inst_ready) begin
            state      <= S_EXEC;
            inst_valid <= 1'b0;
          end
        end

        S_EXEC: begin
          if (exe_done) begin
            if (!redirect_valid) begin
              // Natural 32-bit wrap takes 32'hFFFF_FFFC to 0.
              pc        <= pc + 32'd4;
              state     <= S_REQ;
              req_valid <= 1'b1;
            end else if (redirect_target[1:0] == 2'b00) begin
              pc        <= redirect_target;
              state     <= S_REQ;
              req_valid <= 1'b1;
            end else begin
              // Misaligned target: halt, keep pc, report the bad target.
              state    <= S_ERR;
              fault    <= 1'b1;
              fault_pc <= redirect_target;
            end
          end
        end

        S_ERR: begin
          state <= S_ERR;
        end

        default: begin
          // Unreachable encodings halt the unit rather than fetch garbage.
          state      <= S_ERR;
          fault      <= 1'b1;
          fault_pc   <= pc;
          req_valid  <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        exe_done;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state: the PC the fetch unit should be presenting next and
  // whether it should currently be halted.
  logic [31:0] mpc;
  bit          mfault;

  ifu #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .exe_done(exe_done), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic quiet;
    req_ready = 0; resp_valid = 0; resp_err = 0; inst_ready = 0;
    exe_done = 0; redirect_valid = 0;
  endtask

  task automatic do_reset;
    quiet();
    rst = 1;
    tick();
    rst = 0;
    mpc = RESET_PC;
    mfault = 0;
    chk("rst_req_valid", req_valid, 1);
    chk("rst_req_addr", req_addr, RESET_PC);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_pc", fault_pc, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
  endtask

  task automatic expect_halted(input logic [31:0] fpc);
    chk("halt_fault", fault, 1);
    chk("halt_fault_pc", fault_pc, fpc);
    chk("halt_req_valid", req_valid, 0);
    chk("halt_inst_valid", inst_valid, 0);
    // Nothing but reset may pull the unit out of the halt.
    for (int i = 0; i < 3; i++) begin
      req_ready = 1; inst_ready = 1; resp_valid = 1; resp_data = $urandom();
      exe_done = 1; redirect_valid = $urandom_range(0, 1); redirect_target = $urandom() & ~32'd3;
      tick();
      chk("err_stay_fault", fault, 1);
      chk("err_stay_fault_pc", fault_pc, fpc);
      chk("err_no_req", req_valid, 0);
      chk("err_no_inst", inst_valid, 0);
    end
    quiet();
    mfault = 1;
  endtask

  // One whole instruction, from the REQ offer to the next REQ offer (or halt).
  // Irrelevant inputs are toggled while they must be ignored.
  task automatic do_instr(input int req_stall, input int resp_dly, input bit err,
                          input logic [31:0] data, input int hold_stall, input int exe_dly,
                          input bit redir, input logic [31:0] target);
    chk("req_valid", req_valid, 1);
    chk("req_addr", req_addr, mpc);
    chk("req_no_inst", inst_valid, 0);
    for (int i = 0; i < req_stall; i++) begin
      req_ready = 0;
      resp_valid = $urandom_range(0, 1); resp_data = $urandom(); resp_err = $urandom_range(0, 1);
      exe_done = $urandom_range(0, 1); redirect_valid = $urandom_range(0, 1);
      redirect_target = $urandom();
      tick();
      chk("stall_req_valid", req_valid, 1);
      chk("stall_req_addr", req_addr, mpc);
      chk("stall_no_inst", inst_valid, 0);
      chk("stall_fault", fault, 0);
    end
    quiet();
    req_ready = 1;
    tick();
    req_ready = 0;
    chk("wait_req_valid", req_valid, 0);
    for (int i = 0; i < resp_dly; i++) begin
      exe_done = $urandom_range(0, 1); redirect_valid = $urandom_range(0, 1);
      redirect_target = $urandom(); req_ready = $urandom_range(0, 1);
      tick();
      chk("wait_no_req", req_valid, 0);
      chk("wait_no_inst", inst_valid, 0);
    end
    quiet();
    resp_valid = 1; resp_err = err; resp_data = data;
    tick();
    quiet();
    if (err) begin
      expect_halted(mpc);
      return;
    end
    chk("hold_inst_valid", inst_valid, 1);
    chk("hold_inst", inst, data);
    chk("hold_inst_pc", inst_pc, mpc);
    chk("hold_no_req", req_valid, 0);
    for (int i = 0; i < hold_stall; i++) begin
      resp_valid = $urandom_range(0, 1); resp_data = $urandom(); resp_err = $urandom_range(0, 1);
      exe_done = $urandom_range(0, 1); redirect_valid = $urandom_range(0, 1);
      redirect_target = $urandom(); req_ready = $urandom_range(0, 1);
      tick();
      chk("hstall_inst_valid", inst_valid, 1);
      chk("hstall_inst", inst, data);
      chk("hstall_inst_pc", inst_pc, mpc);
      chk("hstall_no_req", req_valid, 0);
    end
    quiet();
    inst_ready = 1;
    tick();
    inst_ready = 0;
    chk("exec_no_inst", inst_valid, 0);
    chk("exec_no_req", req_valid, 0);
    for (int i = 0; i < exe_dly; i++) begin
      resp_valid = $urandom_range(0, 1); resp_data = $urandom(); resp_err = $urandom_range(0, 1);
      req_ready = $urandom_range(0, 1); inst_ready = $urandom_range(0, 1);
      tick();
      chk("ewait_no_req", req_valid, 0);
      chk("ewait_no_inst", inst_valid, 0);
    end
    quiet();
    exe_done = 1; redirect_valid = redir; redirect_target = target;
    tick();
    quiet();
    if (redir && (target % 4 != 0)) begin
      expect_halted(target);
      return;
    end
    mpc = redir ? target : mpc + 32'd4;
    chk("next_req_valid", req_valid, 1);
    chk("next_req_addr", req_addr, mpc);
    chk("next_fault", fault, 0);
  endtask

  typedef struct {
    bit          err;
    bit          redir;
    logic [31:0] target;
    logic [31:0] data;
    bit          exp_fault;
    logic [31:0] exp_fault_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t0;
    logic [31:0] tgt;
    rst = 1; quiet(); resp_data = 0; redirect_target = 0;

    vecs[0] = '{0, 0, 32'h0,         32'h0000_0013, 0, 32'h0,         32'h8000_0004};
    vecs[1] = '{0, 1, 32'h8000_0100, 32'h0000_006F, 0, 32'h0,         32'h8000_0100};
    vecs[2] = '{0, 1, 32'h8000_0102, 32'h0000_0063, 1, 32'h8000_0102, 32'h8000_0000};
    vecs[3] = '{1, 0, 32'h0,         32'hDEAD_BEEF, 1, 32'h8000_0000, 32'h8000_0000};
    vecs[4] = '{0, 1, 32'h0000_0000, 32'h1234_5678, 0, 32'h0,         32'h0000_0000};
    vecs[5] = '{0, 1, 32'h8000_0003, 32'h0000_0067, 1, 32'h8000_0003, 32'h8000_0000};

    // Table: one zero-wait instruction from reset per row.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      t0 = cyc;
      do_instr(0, 0, vecs[v].err, vecs[v].data, 0, 0, vecs[v].redir, vecs[v].target);
      if (v == 0) chk("latency_4", cyc - t0, 4);
      chk("tbl_fault", fault, vecs[v].exp_fault);
      if (vecs[v].exp_fault) chk("tbl_fault_pc", fault_pc, vecs[v].exp_fault_pc);
      else                   chk("tbl_next_addr", req_addr, vecs[v].exp_addr);
    end

    // Request stalled 3 cycles, response 5 cycles late, decode stalled 4 cycles.
    do_reset();
    do_instr(3, 5, 0, 32'hCAFE_0001, 4, 2, 0, 0);
    chk("stall_seq_addr", req_addr, 32'h8000_0004);

    // Bus error on the third fetch, then reset clears the halt.
    do_reset();
    do_instr(0, 0, 0, 32'h13, 0, 0, 0, 0);
    do_instr(1, 1, 0, 32'h13, 1, 1, 0, 0);
    do_instr(0, 2, 1, 32'h0, 0, 0, 0, 0);
    chk("berr_fault_pc", fault_pc, 32'h8000_0008);
    do_reset();
    chk("berr_clear_addr", req_addr, RESET_PC);

    // PC wrap and spurious strobes while in REQ.
    do_reset();
    do_instr(0, 0, 0, 32'h13, 0, 0, 1, 32'hFFFF_FFFC);
    do_instr(0, 0, 0, 32'h13, 0, 0, 0, 0);
    chk("wrap_addr", req_addr, 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      resp_valid = 1; resp_data = 32'h5555_AAAA; exe_done = 1; redirect_valid = 1;
      redirect_target = 32'h0000_1234;
      tick();
      chk("spur_req_valid", req_valid, 1);
      chk("spur_req_addr", req_addr, 32'h0000_0000);
      chk("spur_inst_valid", inst_valid, 0);
      chk("spur_fault", fault, 0);
    end
    quiet();
    do_instr(0, 0, 0, 32'h13, 0, 0, 0, 0);

    // Reset in the middle of WAIT; the late response must be dropped.
    do_reset();
    req_ready = 1;
    tick();
    req_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    resp_valid = 1; resp_data = 32'hBAD0_BAD0;
    tick();
    resp_valid = 0;
    chk("stale_req_valid", req_valid, 1);
    chk("stale_req_addr", req_addr, RESET_PC);
    chk("stale_inst_valid", inst_valid, 0);
    do_instr(0, 0, 0, 32'h0000_0093, 0, 0, 0, 0);

    // Randomised traffic against the PC/fault model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int kind;
      if (mfault) do_reset();
      kind = $urandom_range(0, 19);
      if (kind == 0)      tgt = ($urandom() & ~32'd3) | $urandom_range(1, 3);
      else                tgt = $urandom() & ~32'd3;
      do_instr($urandom_range(0, 3), $urandom_range(0, 4), ($urandom_range(0, 19) == 0),
               $urandom(), $urandom_range(0, 3), $urandom_range(0, 3),
               (kind < 6), tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL set the PC loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 req_valid  output  1  SHALL mean an instruction-memory fetch request is offered.
REQ-005 req_ready  input  1  SHALL mean memory accepts the request this cycle.
REQ-006 req_addr  output  32  SHALL carry the fetch address (current PC).
REQ-007 resp_valid  input  1  SHALL mean memory returns fetch data this cycle.
REQ-008 resp_data  input  32  SHALL carry the fetched instruction word.
REQ-009 resp_err  input  1  SHALL flag a bus error, qualified by resp_valid.
REQ-010 inst_valid  output  1  SHALL mean an instruction is offered to decode.
REQ-011 inst_ready  input  1  SHALL mean decode accepts the instruction this cycle.
REQ-012 inst  output  32  SHALL carry the held instruction word.
REQ-013 inst_pc  output  32  SHALL carry the PC of the held instruction.
REQ-014 exe_done  input  1  SHALL pulse when execute has resolved the accepted instruction.
REQ-015 redirect_valid  input  1  SHALL mean a taken branch or jump, qualified by exe_done.
REQ-016 redirect_target  input  32  SHALL carry the branch/jump target, qualified by redirect_valid.
REQ-017 fault  output  1  SHALL be a sticky flag: the fetch unit has halted on an error.
REQ-018 fault_pc  output  32  SHALL carry the address that caused the fault.

Function
REQ-019 FSM states SHALL be REQ, WAIT, HOLD, EXEC, ERR; exactly one active.
REQ-020 REQ: req_valid=1, req_addr=pc; req_valid&&req_ready -> WAIT; else stay.
REQ-021 req_valid SHALL be 0 in every state other than REQ.
REQ-022 WAIT: resp_valid&&!resp_err -> latch inst=resp_data, inst_pc=pc, -> HOLD.
REQ-023 WAIT: resp_valid&&resp_err -> fault_pc=pc, -> ERR.
REQ-024 resp_valid in any state other than WAIT SHALL be ignored without side effects.
REQ-025 HOLD: inst_valid=1; inst and inst_pc SHALL stay stable until inst_ready; inst_valid&&inst_ready -> EXEC.
REQ-026 inst_valid SHALL be 0 outside HOLD.
REQ-027 EXEC: exe_done&&!redirect_valid -> pc=pc+4 (mod 2^32, wrap 32'hFFFF_FFFC->0), -> REQ.
REQ-028 EXEC: exe_done&&redirect_valid&&redirect_target[1:0]==0 -> pc=redirect_target, -> REQ.
REQ-029 EXEC: exe_done&&redirect_valid&&redirect_target[1:0]!=0 -> fault_pc=redirect_target, -> ERR; pc unchanged.
REQ-030 exe_done and redirect_valid outside EXEC SHALL be ignored.
REQ-031 ERR: fault=1, no requests, no instructions; leave only via rst.
REQ-032 Min per-instruction latency (zero-wait memory and consumers) SHALL be 4 cycles, REQ entry to next REQ entry.
REQ-033 pc SHALL change only on REQ-027/REQ-028 and on reset.

Reset
REQ-034 On rst: pc=RESET_PC, state=REQ, inst=0, inst_pc=0, fault=0, fault_pc=0.
REQ-035 In the first cycle after reset: req_valid=1, req_addr=RESET_PC, inst_valid=0.
REQ-036 rst SHALL override every state including ERR; a stale resp_valid arriving after mid-WAIT reset SHALL be ignored (state REQ).

Verification
REQ-037 Reset, req_ready=1, resp next cycle data=32'h0000_0013, inst_ready=1, exe_done no redirect -> inst=32'h13, inst_pc=32'h8000_0000, next req_addr=32'h8000_0004 four cycles after first req.
REQ-038 req_ready low 3 cycles, then resp delayed 5 cycles -> req_valid held with constant req_addr; single inst_valid with correct data; no duplicate fetch.
REQ-039 inst_ready low 4 cycles in HOLD -> inst/inst_pc stable; no new request issued.
REQ-040 EXEC exe_done+redirect_valid target=32'h8000_0100 -> next req_addr=32'h8000_0100; target=32'h8000_0102 -> fault=1, fault_pc=32'h8000_0102, req_valid stays 0.
REQ-041 resp_err=1 in WAIT at pc=32'h8000_0008 -> fault=1, fault_pc=32'h8000_0008; subsequent rst -> fault=0, req_addr=RESET_PC.
REQ-042 pc=32'hFFFF_FFFC, exe_done no redirect -> req_addr=32'h0000_0000; spurious resp_valid and exe_done in REQ -> no state change.
